// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one picorv32-style native memory port between two masters.
// Slave-side request and master-side responses are registered; a watchdog ends stalled accesses.
module mem_bus_arbiter #(
  parameter int          ADDR_W         = 32,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic              m0_ready,
  output logic [31:0]       m0_rdata,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic              m1_ready,
  output logic [31:0]       m1_rdata,
  output logic              s_valid,
  output logic [ADDR_W-1:0] s_addr,
  output logic [31:0]       s_wdata,
  output logic [3:0]        s_wstrb,
  input  logic              s_ready,
  input  logic [31:0]       s_rdata,
  output logic              grant,
  output logic              timeout_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              grant_q, grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              s_valid_q, s_valid_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [31:0]       s_wdata_q, s_wdata_d;
  logic [3:0]        s_wstrb_q, s_wstrb_d;
  logic              m0_ready_q, m0_ready_d;
  logic              m1_ready_q, m1_ready_d;
  logic [31:0]       m0_rdata_q, m0_rdata_d;
  logic [31:0]       m1_rdata_q, m1_rdata_d;
  logic              tout_q, tout_d;
  logic              pick;
  logic              wd_fire;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    s_valid_d  = s_valid_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    s_wstrb_d  = s_wstrb_q;
    m0_ready_d = 1'b0;
    m1_ready_d = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    tout_d     = 1'b0;
    pick       = grant_q;
    // s_ready has priority over the watchdog when both land in the same cycle
    wd_fire    = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST) && !s_ready;

    case (state_q)
      ST_IDLE: begin
        if (m0_valid || m1_valid) begin
          if (m0_valid && m1_valid) pick = ~grant_q;
          else                      pick = m1_valid;
          grant_d   = pick;
          cnt_d     = '0;
          s_valid_d = 1'b1;
          s_addr_d  = pick ? m1_addr  : m0_addr;
          s_wdata_d = pick ? m1_wdata : m0_wdata;
          s_wstrb_d = pick ? m1_wstrb : m0_wstrb;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (s_ready || wd_fire) begin
          s_valid_d = 1'b0;
          tout_d    = !s_ready;
          state_d   = ST_RESP;
          if (grant_q) begin
            m1_ready_d = 1'b1;
            m1_rdata_d = s_ready ? s_rdata : ERR_DATA;
          end else begin
            m0_ready_d = 1'b1;
            m0_rdata_d = s_ready ? s_rdata : ERR_DATA;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= 1'b1;
      cnt_q      <= '0;
      s_valid_q  <= 1'b0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_wstrb_q  <= '0;
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      s_valid_q  <= s_valid_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      s_wstrb_q  <= s_wstrb_d;
      m0_ready_q <= m0_ready_d;
      m1_ready_q <= m1_ready_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      tout_q     <= tout_d;
    end
  end

  assign s_valid     = s_valid_q;
  assign s_addr      = s_addr_q;
  assign s_wdata     = s_wdata_q;
  assign s_wstrb     = s_wstrb_q;
  assign m0_ready    = m0_ready_q;
  assign m1_ready    = m1_ready_q;
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;
  assign grant       = grant_q;
  assign timeout_err = tout_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of grant order, latency and response data.
module tb_mem_bus_arbiter;

  localparam int          ADDR_W  = 32;
  localparam int          TMO     = 8;
  localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

  logic              clk;
  logic              reset;
  logic              m0_valid, m1_valid;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [31:0]       m0_wdata, m1_wdata;
  logic [3:0]        m0_wstrb, m1_wstrb;
  logic              m0_ready, m1_ready;
  logic [31:0]       m0_rdata, m1_rdata;
  logic              s_valid;
  logic [ADDR_W-1:0] s_addr;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic              s_ready;
  logic [31:0]       s_rdata;
  logic              grant;
  logic              timeout_err;

  int errors = 0;
  int checks = 0;
  bit last_g;

  mem_bus_arbiter #(
    .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO), .ERR_DATA(ERR_VAL)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_time_limit reached before summary");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m0_valid = 0; m1_valid = 0; s_ready = 0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    m0_wstrb = '0; m1_wstrb = '0; s_rdata = '0;
    tick(); tick();
    checks++;
    if ({s_valid, m0_ready, m1_ready, timeout_err, grant} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=00001", {s_valid, m0_ready, m1_ready, timeout_err, grant});
    end
    checks++;
    if ({s_addr, s_wdata, s_wstrb, m0_rdata, m1_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data got addr=%h wdata=%h wstrb=%h r0=%h r1=%h exp all 0",
               s_addr, s_wdata, s_wstrb, m0_rdata, m1_rdata);
    end
    reset = 1'b0;
    last_g = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    m0_valid = 1; m0_addr = 32'h0000_0040; m0_wstrb = 4'h0; m0_wdata = $urandom;
    tick();
    checks++;
    if (s_valid !== 1'b1 || grant !== 1'b0 || s_addr !== 32'h40 || s_wstrb !== 4'h0) begin
      errors++;
      $display("FAIL read_grant got v=%b g=%b addr=%h strb=%h exp v=1 g=0 addr=40 strb=0",
               s_valid, grant, s_addr, s_wstrb);
    end
    tick();
    checks++;
    if (s_valid !== 1'b1 || m0_ready !== 1'b0) begin
      errors++;
      $display("FAIL read_busy got v=%b rdy=%b exp v=1 rdy=0", s_valid, m0_ready);
    end
    tick();
    s_ready = 1; s_rdata = 32'h1234_5678;
    tick();
    s_ready = 0;
    checks++;
    if (m0_ready !== 1'b1 || m1_ready !== 1'b0 || m0_rdata !== 32'h1234_5678 ||
        timeout_err !== 1'b0 || s_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_resp got r0=%b r1=%b data=%h to=%b v=%b exp r0=1 r1=0 data=12345678 to=0 v=0",
               m0_ready, m1_ready, m0_rdata, timeout_err, s_valid);
    end
    m0_valid = 0;
    tick();
    checks++;
    if (m0_ready !== 1'b0 || m0_rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL read_hold got rdy=%b data=%h exp rdy=0 data=12345678", m0_ready, m0_rdata);
    end
    last_g = 1'b0;
  endtask

  task automatic test_write();
    logic [31:0] rd;
    bit stable;
    rd = $urandom;
    m1_valid = 1; m1_addr = 32'h2000_0000; m1_wdata = 32'h41; m1_wstrb = 4'b0001;
    tick();
    stable = 1;
    for (int i = 0; i < 4; i++) begin
      if (s_valid !== 1'b1 || s_addr !== 32'h2000_0000 || s_wdata !== 32'h41 || s_wstrb !== 4'b0001)
        stable = 0;
      if (i < 3) tick();
    end
    checks++;
    if (!stable || grant !== 1'b1) begin
      errors++;
      $display("FAIL write_stable got stable=%0d g=%b addr=%h wd=%h strb=%h exp stable=1 g=1",
               stable, grant, s_addr, s_wdata, s_wstrb);
    end
    // A new master-side value must not disturb the latched request
    m1_addr = 32'hFFFF_FFFF;
    s_ready = 1; s_rdata = rd;
    tick();
    s_ready = 0;
    checks++;
    if (m1_ready !== 1'b1 || m0_ready !== 1'b0 || m1_rdata !== rd || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL write_resp got r1=%b r0=%b data=%h to=%b exp r1=1 r0=0 data=%h to=0",
               m1_ready, m0_ready, m1_rdata, timeout_err, rd);
    end
    m1_valid = 0;
    tick();
    checks++;
    if (m1_ready !== 1'b0 || s_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_done got r1=%b v=%b exp 0 0", m1_ready, s_valid);
    end
    last_g = 1'b1;
  endtask

  task automatic test_contention();
    int n0, n1;
    logic exp_g;
    n0 = 0; n1 = 0;
    m0_valid = 1; m0_addr = 32'h100; m0_wstrb = 0;
    m1_valid = 1; m1_addr = 32'h200; m1_wstrb = 0;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 1);
      tick();
      checks++;
      if (s_valid !== 1'b1 || grant !== exp_g || s_addr !== (exp_g ? 32'h200 : 32'h100)) begin
        errors++;
        $display("FAIL contention_grant%0d got v=%b g=%b addr=%h exp v=1 g=%b", i, s_valid, grant, s_addr, exp_g);
      end
      s_ready = 1;
      tick();
      s_ready = 0;
      n0 += int'(m0_ready); n1 += int'(m1_ready);
      checks++;
      if (m0_ready !== !exp_g || m1_ready !== exp_g) begin
        errors++;
        $display("FAIL contention_ready%0d got r0=%b r1=%b exp r0=%b r1=%b", i, m0_ready, m1_ready, !exp_g, exp_g);
      end
      tick();
      checks++;
      if (s_valid !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0) begin
        errors++;
        $display("FAIL contention_resp_idle%0d got v=%b r0=%b r1=%b exp 0 0 0", i, s_valid, m0_ready, m1_ready);
      end
    end
    checks++;
    if (n0 != 2 || n1 != 2) begin
      errors++;
      $display("FAIL contention_count got n0=%0d n1=%0d exp 2 2", n0, n1);
    end
    m0_valid = 0; m1_valid = 0;
    last_g = 1'b1;
  endtask

  task automatic test_watchdog();
    int n;
    m0_valid = 1; m0_addr = 32'h80; m0_wstrb = 0;
    s_ready = 0; s_rdata = 32'h5555_AAAA;
    tick();
    n = 0;
    while (s_valid === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    checks++;
    if (n != TMO) begin
      errors++;
      $display("FAIL watchdog_len got=%0d exp=%0d", n, TMO);
    end
    checks++;
    if (m0_ready !== 1'b1 || m0_rdata !== ERR_VAL || timeout_err !== 1'b1 || m1_ready !== 1'b0) begin
      errors++;
      $display("FAIL watchdog_resp got r0=%b data=%h to=%b r1=%b exp r0=1 data=deadbeef to=1 r1=0",
               m0_ready, m0_rdata, timeout_err, m1_ready);
    end
    m0_valid = 0;
    tick();
    checks++;
    if (timeout_err !== 1'b0 || m0_ready !== 1'b0 || s_valid !== 1'b0) begin
      errors++;
      $display("FAIL watchdog_idle got to=%b r0=%b v=%b exp 0 0 0", timeout_err, m0_ready, s_valid);
    end
    last_g = 1'b0;
  endtask

  task automatic test_race();
    m1_valid = 1; m1_addr = 32'h300; m1_wstrb = 0;
    tick();
    for (int k = 2; k <= TMO; k++) tick();
    checks++;
    if (s_valid !== 1'b1 || grant !== 1'b1) begin
      errors++;
      $display("FAIL race_busy got v=%b g=%b exp 1 1", s_valid, grant);
    end
    s_ready = 1; s_rdata = 32'hCAFE_0001;
    tick();
    s_ready = 0;
    checks++;
    if (m1_ready !== 1'b1 || m1_rdata !== 32'hCAFE_0001 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL race_resp got r1=%b data=%h to=%b exp r1=1 data=cafe0001 to=0",
               m1_ready, m1_rdata, timeout_err);
    end
    m1_valid = 0;
    tick();
    last_g = 1'b1;
  endtask

  task automatic test_reset_mid();
    m0_valid = 1; m0_addr = 32'h440; m0_wstrb = 4'hF; m0_wdata = 32'h77;
    tick(); tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({s_valid, m0_ready, m1_ready, timeout_err, grant} !== 5'b00001 || s_addr !== '0) begin
      errors++;
      $display("FAIL reset_mid got ctrl=%b addr=%h exp ctrl=00001 addr=0",
               {s_valid, m0_ready, m1_ready, timeout_err, grant}, s_addr);
    end
    m0_valid = 0;
    #2 reset = 1'b0;
    tick();
    checks++;
    if (m0_ready !== 1'b0 || s_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_noresp got r0=%b v=%b exp 0 0", m0_ready, s_valid);
    end
    m1_valid = 1; m1_addr = 32'h880; m1_wstrb = 0;
    tick();
    checks++;
    if (s_valid !== 1'b1 || grant !== 1'b1 || s_addr !== 32'h880) begin
      errors++;
      $display("FAIL reset_mid_regrant got v=%b g=%b addr=%h exp 1 1 880", s_valid, grant, s_addr);
    end
    s_ready = 1; s_rdata = 32'h0BAD_F00D;
    tick();
    s_ready = 0;
    checks++;
    if (m1_ready !== 1'b1 || m1_rdata !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL reset_mid_resp got r1=%b data=%h exp 1 0badf00d", m1_ready, m1_rdata);
    end
    m1_valid = 0;
    tick();
    last_g = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] addr [2];
    logic [31:0] wdat [2];
    logic [3:0]  strb [2];
    bit          pend [2];
    logic        w;
    int          d, n, exp_len;
    bit          exp_to, stable;
    logic [31:0] srd, exp_data, got_data;
    pend[0] = 0; pend[1] = 0;
    for (int t = 0; t < 40; t++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && ($urandom_range(0, 2) != 0 || (m == 1 && !pend[0]))) begin
          pend[m] = 1;
          addr[m] = $urandom;
          wdat[m] = $urandom;
          strb[m] = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        end
      end
      m0_valid = pend[0]; m0_addr = addr[0]; m0_wdata = wdat[0]; m0_wstrb = strb[0];
      m1_valid = pend[1]; m1_addr = addr[1]; m1_wdata = wdat[1]; m1_wstrb = strb[1];
      w = (pend[0] && pend[1]) ? !last_g : !pend[0];
      last_g = w;
      d = $urandom_range(0, 11);
      srd = $urandom;
      tick();
      checks++;
      if (s_valid !== 1'b1 || grant !== w || s_addr !== addr[w] || s_wdata !== wdat[w] || s_wstrb !== strb[w]) begin
        errors++;
        $display("FAIL rand%0d_grant got v=%b g=%b addr=%h wd=%h st=%h exp v=1 g=%b addr=%h wd=%h st=%h",
                 t, s_valid, grant, s_addr, s_wdata, s_wstrb, w, addr[w], wdat[w], strb[w]);
      end
      n = 0; stable = 1;
      while (s_valid === 1'b1 && n < 20) begin
        n++;
        if (s_addr !== addr[w] || s_wdata !== wdat[w] || s_wstrb !== strb[w] || m0_ready || m1_ready)
          stable = 0;
        s_ready = (n == d + 1);
        s_rdata = (n == d + 1) ? srd : $urandom;
        tick();
      end
      exp_to   = (d + 1 > TMO);
      exp_len  = exp_to ? TMO : d + 1;
      exp_data = exp_to ? ERR_VAL : srd;
      got_data = w ? m1_rdata : m0_rdata;
      checks++;
      if (n != exp_len || !stable) begin
        errors++;
        $display("FAIL rand%0d_busy got len=%0d stable=%0d exp len=%0d stable=1", t, n, stable, exp_len);
      end
      checks++;
      if ({m1_ready, m0_ready} !== (w ? 2'b10 : 2'b01) || timeout_err !== exp_to || got_data !== exp_data) begin
        errors++;
        $display("FAIL rand%0d_resp got r1r0=%b to=%b data=%h exp r1r0=%b to=%b data=%h",
                 t, {m1_ready, m0_ready}, timeout_err, got_data, (w ? 2'b10 : 2'b01), exp_to, exp_data);
      end
      pend[w] = 0;
      m0_valid = pend[0]; m1_valid = pend[1];
      s_ready = ($urandom_range(0, 1) == 1);
      tick();
      s_ready = 0;
      checks++;
      if (s_valid !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0 || timeout_err !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_idle got v=%b r0=%b r1=%b to=%b exp 0 0 0 0",
                 t, s_valid, m0_ready, m1_ready, timeout_err);
      end
    end
    m0_valid = 0; m1_valid = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_contention();
    test_watchdog();
    test_race();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
